// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: issues look-ahead pixel requests and
// aligns the returned colour with the sync outputs.
module vga_timing_gen #(
    parameter int H_ACTIVE                = 1920,
    parameter int H_FP                    = 88,
    parameter int H_SYNC                  = 44,
    parameter int H_BP                    = 148,
    parameter int V_ACTIVE                = 1080,
    parameter int V_FP                    = 4,
    parameter int V_SYNC                  = 5,
    parameter int V_BP                    = 36,
    parameter int HSYNC_POL               = 1,
    parameter int VSYNC_POL               = 1,
    parameter int PIXEL_INTERFACE_LATENCY = 4,
    parameter int COLOR_BITS              = 12,
    parameter int DIM_WIDTH               = 12
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en,
    output logic                  req_valid,
    output logic [DIM_WIDTH-1:0]  req_x,
    output logic [DIM_WIDTH-1:0]  req_y,
    input  logic [COLOR_BITS-1:0] px_color,
    output logic                  vga_hs,
    output logic                  vga_vs,
    output logic [3:0]            vga_r,
    output logic [3:0]            vga_g,
    output logic [3:0]            vga_b,
    output logic                  sof,
    output logic                  eof,
    output logic [15:0]           frame_count
);

    localparam int HTS = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VTS = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int LAT = PIXEL_INTERFACE_LATENCY;
    localparam int REP = 12 / COLOR_BITS;

    // Inclusive bounds keep every constant below HTS/VTS, so they always fit DIM_WIDTH.
    localparam logic [DIM_WIDTH-1:0] H_LAST       = DIM_WIDTH'(HTS - 1);
    localparam logic [DIM_WIDTH-1:0] V_LAST       = DIM_WIDTH'(VTS - 1);
    localparam logic [DIM_WIDTH-1:0] H_ACT_LAST   = DIM_WIDTH'(H_ACTIVE - 1);
    localparam logic [DIM_WIDTH-1:0] V_ACT_LAST   = DIM_WIDTH'(V_ACTIVE - 1);
    localparam logic [DIM_WIDTH-1:0] H_SYNC_FIRST = DIM_WIDTH'(H_ACTIVE + H_FP);
    localparam logic [DIM_WIDTH-1:0] H_SYNC_LAST  = DIM_WIDTH'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [DIM_WIDTH-1:0] V_SYNC_FIRST = DIM_WIDTH'(V_ACTIVE + V_FP);
    localparam logic [DIM_WIDTH-1:0] V_SYNC_LAST  = DIM_WIDTH'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [DIM_WIDTH-1:0] ONE          = DIM_WIDTH'(1);
    localparam logic                 HS_ACT       = (HSYNC_POL != 0);
    localparam logic                 VS_ACT       = (VSYNC_POL != 0);

    logic [DIM_WIDTH-1:0]  cx, cy;
    logic                  hs_raw, vs_raw;
    logic [LAT-1:0]        valid_sr, hs_sr, vs_sr;
    logic [COLOR_BITS-1:0] color_q;
    logic                  hs_q, vs_q;
    logic [11:0]           rgb;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cx <= '0;
            cy <= '0;
        end else if (!en) begin
            cx <= '0;
            cy <= '0;
        end else if (cx == H_LAST) begin
            cx <= '0;
            cy <= (cy == V_LAST) ? '0 : cy + ONE;
        end else begin
            cx <= cx + ONE;
        end
    end

    assign req_x     = cx;
    assign req_y     = cy;
    assign req_valid = en && (cx <= H_ACT_LAST) && (cy <= V_ACT_LAST);
    assign hs_raw    = en && (cx >= H_SYNC_FIRST) && (cx <= H_SYNC_LAST);
    assign vs_raw    = en && (cy >= V_SYNC_FIRST) && (cy <= V_SYNC_LAST);
    assign sof       = en && (cx == '0) && (cy == '0);
    assign eof       = en && (cx == H_LAST) && (cy == V_LAST);

    // NOTE: the delay stages are reset so a mid-frame reset can never release
    // stale valid/sync bits onto the pins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_sr <= '0;
            hs_sr    <= '0;
            vs_sr    <= '0;
            color_q  <= '0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
        end else begin
            valid_sr <= LAT'({valid_sr, req_valid});
            hs_sr    <= LAT'({hs_sr, hs_raw});
            vs_sr    <= LAT'({vs_sr, vs_raw});
            color_q  <= valid_sr[LAT-1] ? px_color : '0;
            hs_q     <= hs_sr[LAT-1];
            vs_q     <= vs_sr[LAT-1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_count <= 16'd0;
        end else if (eof) begin
            frame_count <= frame_count + 16'd1;
        end
    end

    // Narrow colour sources are replicated to fill all twelve pin bits.
    assign rgb    = {REP{color_q}};
    assign vga_r  = rgb[11:8];
    assign vga_g  = rgb[7:4];
    assign vga_b  = rgb[3:0];
    assign vga_hs = hs_q ~^ HS_ACT;
    assign vga_vs = vs_q ~^ VS_ACT;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a 14x8 raster, with a second
// instance using inverted sync polarity.
module tb_vga_timing_gen;

    localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 3, H_BP = 1;
    localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 2, V_BP = 1;
    localparam int L   = 2;
    localparam int HTS = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VTS = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FT  = HTS * VTS;

    typedef struct packed {
        logic v;
        logic hs;
        logic vs;
        logic x3;
    } req_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        en = 1'b0;
    logic [0:0]  px_color = 1'b0;

    logic        req_valid, vga_hs, vga_vs, sof, eof;
    logic [11:0] req_x, req_y;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic [15:0] frame_count;

    logic        req_valid_b, vga_hs_b, vga_vs_b, sof_b, eof_b;
    logic [11:0] req_x_b, req_y_b;
    logic [3:0]  vga_r_b, vga_g_b, vga_b_b;
    logic [15:0] frame_count_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HSYNC_POL(1), .VSYNC_POL(1), .PIXEL_INTERFACE_LATENCY(L),
        .COLOR_BITS(1), .DIM_WIDTH(12)
    ) dut (
        .clk(clk), .resetn(resetn), .en(en),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
        .px_color(px_color), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .sof(sof), .eof(eof), .frame_count(frame_count)
    );

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HSYNC_POL(0), .VSYNC_POL(0), .PIXEL_INTERFACE_LATENCY(L),
        .COLOR_BITS(1), .DIM_WIDTH(12)
    ) dut_neg (
        .clk(clk), .resetn(resetn), .en(en),
        .req_valid(req_valid_b), .req_x(req_x_b), .req_y(req_y_b),
        .px_color(px_color), .vga_hs(vga_hs_b), .vga_vs(vga_vs_b),
        .vga_r(vga_r_b), .vga_g(vga_g_b), .vga_b(vga_b_b),
        .sof(sof_b), .eof(eof_b), .frame_count(frame_count_b)
    );

    // Model state: linear raster position plus the history of issued requests.
    int          pos;
    logic [15:0] frames;
    logic        en_cur, px_cur;
    req_t        hist [0:L];
    int          exp_x, exp_y;
    logic        exp_valid, exp_hs_raw, exp_vs_raw, exp_sof, exp_eof;
    logic        exp_hs_pin, exp_vs_pin;
    logic [3:0]  exp_rgb;
    int          cyc;
    bit          cmp_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void set_req();
        exp_x      = pos % HTS;
        exp_y      = pos / HTS;
        exp_valid  = en_cur && (exp_x < H_ACTIVE) && (exp_y < V_ACTIVE);
        exp_hs_raw = en_cur && (exp_x >= H_ACTIVE + H_FP) && (exp_x < H_ACTIVE + H_FP + H_SYNC);
        exp_vs_raw = en_cur && (exp_y >= V_ACTIVE + V_FP) && (exp_y < V_ACTIVE + V_FP + V_SYNC);
        exp_sof    = en_cur && (pos == 0);
        exp_eof    = en_cur && (pos == FT - 1);
    endfunction

    function automatic void model_reset();
        pos        = 0;
        frames     = 16'd0;
        for (int i = 0; i <= L; i++) hist[i] = '0;
        exp_hs_pin = 1'b0;
        exp_vs_pin = 1'b0;
        exp_rgb    = 4'h0;
    endfunction

    // One clock edge: update the model, then drive the next cycle's inputs.
    // px_color follows the stimulus rule: 1 when the request two edges back was x=3.
    task automatic advance(input logic next_en, input logic force_px);
        @(posedge clk);
        #1;
        if (!resetn) begin
            model_reset();
        end else begin
            for (int i = L; i > 0; i--) hist[i] = hist[i-1];
            hist[0]    = '{v: exp_valid, hs: exp_hs_raw, vs: exp_vs_raw, x3: (en_cur && exp_x == 3)};
            exp_hs_pin = hist[L].hs;
            exp_vs_pin = hist[L].vs;
            exp_rgb    = (hist[L].v && px_cur) ? 4'hF : 4'h0;
            if (en_cur && pos == FT - 1) frames++;
            pos = en_cur ? (pos + 1) % FT : 0;
        end
        if (en_cur) cyc++;
        if (!en_cur && next_en) cyc = 0;
        en_cur   = next_en;
        en       = next_en;
        px_cur   = force_px || hist[1].x3;
        px_color = px_cur;
        set_req();
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("req_valid", 32'(req_valid), 32'(exp_valid));
            check("req_x", 32'(req_x), 32'(exp_x));
            check("req_y", 32'(req_y), 32'(exp_y));
            check("sof", 32'(sof), 32'(exp_sof));
            check("eof", 32'(eof), 32'(exp_eof));
            check("frame_count", 32'(frame_count), 32'(frames));
            check("vga_hs", 32'(vga_hs), 32'(exp_hs_pin));
            check("vga_vs", 32'(vga_vs), 32'(exp_vs_pin));
            check("rgb", 32'({vga_r, vga_g, vga_b}), 32'({3{exp_rgb}}));
            check("vga_hs_neg", 32'(vga_hs_b), 32'(!exp_hs_pin));
            check("vga_vs_neg", 32'(vga_vs_b), 32'(!exp_vs_pin));
            check("rgb_neg", 32'({vga_r_b, vga_g_b, vga_b_b}), 32'({3{exp_rgb}}));
        end
    end

    initial begin
        int first_hs, first_vs, first_rgb;
        int hs_cnt, vs_cnt, rgb_cnt, force_cnt;
        logic [15:0] fc_saved;

        en_cur = 1'b0;
        px_cur = 1'b0;
        cyc    = 0;
        model_reset();
        set_req();

        // Reset levels
        #2;
        check("rst_vga_hs", 32'(vga_hs), 32'd0);
        check("rst_vga_vs", 32'(vga_vs), 32'd0);
        check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        check("rst_vga_hs_neg", 32'(vga_hs_b), 32'd1);
        check("rst_vga_vs_neg", 32'(vga_vs_b), 32'd1);
        check("rst_frame_count", 32'(frame_count), 32'd0);

        advance(1'b0, 1'b0);
        cmp_on = 1'b1;
        advance(1'b0, 1'b0);
        resetn = 1'b1;
        repeat (3) advance(1'b0, 1'b0);

        // Three full frames with the x=3 colour pattern
        first_hs = -1; first_vs = -1; first_rgb = -1;
        hs_cnt = 0; vs_cnt = 0; rgb_cnt = 0;
        for (int k = 0; k < 337; k++) begin
            advance(1'b1, 1'b0);
            if (cyc == 0) check("sof_at_0", 32'(sof), 32'd1);
            if (cyc < 112) begin
                if (vga_hs) begin hs_cnt++; if (first_hs < 0) first_hs = cyc; end
                if (vga_vs) begin vs_cnt++; if (first_vs < 0) first_vs = cyc; end
                if (vga_r == 4'hF) begin rgb_cnt++; if (first_rgb < 0) first_rgb = cyc; end
            end
            if (cyc == 111) check("eof_at_111", 32'(eof), 32'd1);
            if (cyc == 112) check("frames_at_112", 32'(frame_count), 32'd1);
            if (cyc == 336) check("frames_at_336", 32'(frame_count), 32'd3);
        end
        check("first_rgb_cycle", 32'(first_rgb), 32'd6);
        check("rgb_cycles_frame0", 32'(rgb_cnt), 32'd4);
        check("first_hs_cycle", 32'(first_hs), 32'd13);
        check("hs_cycles_frame0", 32'(hs_cnt), 32'd22);
        check("first_vs_cycle", 32'(first_vs), 32'd73);
        check("vs_cycles_frame0", 32'(vs_cnt), 32'd28);

        // Colour forced high: only the 32 active pixels may show it
        force_cnt = 0;
        for (int k = 0; k < FT; k++) begin
            advance(1'b1, 1'b1);
            if (vga_g == 4'hF) force_cnt++;
        end
        check("forced_rgb_cycles", 32'(force_cnt), 32'd32);

        // Abandon a frame at row 2, then restart
        repeat (30) advance(1'b1, 1'b0);
        fc_saved = frame_count;
        check("frames_before_drop", 32'(fc_saved), 32'd4);
        repeat (6) advance(1'b0, 1'b0);
        advance(1'b1, 1'b0);
        check("restart_sof", 32'(sof), 32'd1);
        check("restart_pos", 32'({req_y, req_x}), 32'd0);
        check("restart_frames", 32'(frame_count), 32'(fc_saved));

        // Asynchronous reset in the middle of a line
        repeat (20) advance(1'b1, 1'b0);
        #1;
        resetn = 1'b0;
        en     = 1'b0;
        #1;
        check("async_vga_hs", 32'(vga_hs), 32'd0);
        check("async_vga_vs", 32'(vga_vs), 32'd0);
        check("async_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        check("async_req_valid", 32'(req_valid), 32'd0);
        check("async_pos", 32'({req_y, req_x}), 32'd0);
        check("async_frame_count", 32'(frame_count), 32'd0);
        check("async_vga_hs_neg", 32'(vga_hs_b), 32'd1);
        model_reset();
        en_cur   = 1'b0;
        px_cur   = 1'b0;
        px_color = 1'b0;
        set_req();
        repeat (3) advance(1'b0, 1'b0);
        resetn = 1'b1;
        repeat (4) advance(1'b0, 1'b0);
        for (int k = 0; k < 120; k++) advance(1'b1, 1'b0);
        check("frames_after_reset", 32'(frame_count), 32'd1);

        @(negedge clk);
        cmp_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised raster timing generator for the VGA output path; successor to the fixed-mode 1080p generator.
- Horizontal/vertical timing, sync polarities, pixel-source latency and colour width are all parameters.
- Issues a look-ahead pixel request (x, y, valid) to the frame-buffer/pixel source and accepts its colour a fixed number of cycles later.
- Aligns colour and sync outputs, and adds a run enable, start-of-frame/end-of-frame strobes and a frame counter.

Parameters:
H_ACTIVE, 1920, visible pixels per line
H_FP, 88, horizontal front porch (cycles)
H_SYNC, 44, horizontal sync width
H_BP, 148, horizontal back porch
V_ACTIVE, 1080, visible lines per frame
V_FP, 4, vertical front porch (lines)
V_SYNC, 5, vertical sync width
V_BP, 36, vertical back porch
HSYNC_POL, 1, active level of vga_hs (1 = active high)
VSYNC_POL, 1, active level of vga_vs
PIXEL_INTERFACE_LATENCY, 4, clock edges from request to px_color valid; legal range is 1 or more
COLOR_BITS, 12, colour width; must be 12, or must divide 12
DIM_WIDTH, 12, width of x/y counters; 2^DIM_WIDTH must be at least max(HTS, VTS)

Derived values: HTS = H_ACTIVE + H_FP + H_SYNC + H_BP, and VTS = V_ACTIVE + V_FP + V_SYNC + V_BP.

Ports:
clk  in  1  pixel clock
resetn  in  1  asynchronous active-low reset
en  in  1  run enable
req_valid  out  1  current request position is in the active area
req_x  out  DIM_WIDTH  request column
req_y  out  DIM_WIDTH  request row
px_color  in  COLOR_BITS  colour for the request issued PIXEL_INTERFACE_LATENCY edges earlier
vga_hs  out  1  horizontal sync
vga_vs  out  1  vertical sync
vga_r  out  4  red
vga_g  out  4  green
vga_b  out  4  blue
sof  out  1  one-cycle strobe: request position is (0,0)
eof  out  1  one-cycle strobe: request position is (HTS-1,VTS-1)
frame_count  out  16  completed frames, wrapping

Behaviour:
Reset and clocking
- One clock, clk; asynchronous active-low reset, resetn.
- resetn low, at any time including mid-frame, immediately sets: counters to (0,0); colour register to 0; all delay stages to inactive; frame_count to 0.
- During reset, vga_hs = ~HSYNC_POL, vga_vs = ~VSYNC_POL and rgb = 0.

Counters
- cx counts 0..HTS-1. cy counts 0..VTS-1 and advances only when cx = HTS-1. Both wrap to 0; there are no out-of-range states.
- While en = 0, cx and cy are held at 0 and req_valid, sof and eof are forced to 0.
- In the first cycle en is 1, the request position is (0,0) and sof = 1.
- Dropping en mid-frame abandons the frame. The pipeline keeps flushing; frame_count does not increment.

Request outputs (combinational from the counter registers)
- req_x = cx, req_y = cy.
- req_valid = en & (cx < H_ACTIVE) & (cy < V_ACTIVE).

Horizontal and vertical regions
- Horizontal order: active, front porch, sync, back porch.
- hs_raw = 1 when H_ACTIVE+H_FP <= cx < H_ACTIVE+H_FP+H_SYNC.
- vs_raw uses the same rule on cy with the V_* parameters and changes at the line boundary (cx wrap).
- hs_raw and vs_raw are forced to 0 when en = 0.

Alignment pipeline
- req_valid, hs_raw and vs_raw each pass through a PIXEL_INTERFACE_LATENCY-stage shift register.
- The output register captures, on each edge:
  - colour = px_color if the delayed valid is 1, else 0;
  - hs = delayed hs_raw;
  - vs = delayed vs_raw.
- Total latency from request to pins is PIXEL_INTERFACE_LATENCY+1 edges, identical for colour, hs and vs.
- vga_hs = registered hs XNOR HSYNC_POL; vga_vs likewise with VSYNC_POL.
- Colour mapping onto {vga_r, vga_g, vga_b}:
  - COLOR_BITS = 12: direct.
  - Otherwise: the colour replicated 12/COLOR_BITS times.

Frame strobes and counter
- sof and eof are aligned to the request, not to the pins.
- frame_count increments by 1 on every clock where eof = 1, wrapping from 0xFFFF to 0.

Test Plan:
Bench parameters for all scenarios: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=1 (HTS=14); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (VTS=8); PIXEL_INTERFACE_LATENCY=2; COLOR_BITS=1; pols=1.
1. Reset then en=1:
   - sof at cycle 0;
   - req_valid high for cycles 0-7 of each line on rows 0-3;
   - eof at cycle 111;
   - frame_count = 1 after cycle 111, and 3 after 336 cycles.
2. Drive px_color = 1 only when the request issued 2 edges earlier had req_x = 3, and 0 otherwise:
   - vga_r/g/b = 0xF exactly one cycle per active line, 3 edges after the x=3 request;
   - rgb = 0 during blanking, even when px_color is forced to 1.
3. hs alignment: vga_hs high for 3 cycles, starting 3 edges after the request with cx = 10, on every line.
4. vs alignment: vga_vs high for 28 cycles, starting 3 edges after the request at (0,5).
5. Sync polarity: HSYNC_POL=0 and VSYNC_POL=0 → both sync outputs inverted; rgb timing unchanged; reset level 1.
6. Interruptions:
   - en=0 at row 2 → next en=1 gives sof and position (0,0), and frame_count is unchanged.
   - resetn pulsed low mid-line → all outputs go inactive immediately (asynchronously), and frame_count = 0.
